rr_mux32_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 32:1 mux output channel among 32 requesters.

---
 rtl/rr_mux32_arbiter.sv | 101 ++++++++++
 tb/tb_rr_mux32_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux32_arbiter.sv
// Round-robin arbiter that shares one 32:1 mux output among 32 requesters.
// A grant is held for up to MAX_BURST accepted beats under a valid/ready handshake.
module rr_mux32_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req,
  output logic [31:0] gnt,
  output logic [4:0]  sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [4:0]    ptr_q, ptr_d;
  logic [4:0]    sel_q, sel_d;
  logic [31:0]   gnt_q, gnt_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [4:0] pick;
  logic       found;
  logic       beat;
  logic       release_now;

  // Circular priority search starting at ptr; the first hit wins.
  always_comb begin
    logic [4:0] idx;
    idx   = '0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < 32; k++) begin
      idx = ptr_q + 5'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign busy        = (state_q == BUSY);
  assign out_valid   = busy && req[sel_q];
  assign beat        = out_valid && out_ready;
  assign release_now = busy && (!req[sel_q] || (beat && (beat_cnt_q == LAST_BEAT)));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BUSY;
          sel_d      = pick;
          gnt_d      = 32'h1 << pick;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          // Advance past the served requester so it goes to the back of the line.
          state_d    = IDLE;
          gnt_d      = '0;
          ptr_d      = sel_q + 5'd1;
          beat_cnt_d = '0;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

endmodule

// File: tb/tb_rr_mux32_arbiter.sv
// Directed bench for rr_mux32_arbiter: per-cycle comparison against a
// transaction-level arbiter model plus literal checks on the grant history.
module tb_rr_mux32_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] req = '0;
  logic        out_ready = 1'b0;
  logic [31:0] gnt;
  logic [4:0]  sel;
  logic        out_valid;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  rr_mux32_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Model: who owns the channel, where the next search starts, beats so far.
  bit started = 0;
  bit m_busy  = 0;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_beats = 0;

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      m_busy  = 0;
      m_ptr   = 0;
      m_sel   = 0;
      m_beats = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 32; k++) begin
        if (!m_busy && req[(m_ptr + k) % 32]) begin
          m_sel   = (m_ptr + k) % 32;
          m_busy  = 1;
          m_beats = 0;
        end
      end
    end else begin
      if (!req[m_sel]) begin
        m_busy = 0;
        m_ptr  = (m_sel + 1) % 32;
      end else if (out_ready) begin
        m_beats++;
        if (m_beats == MB) begin
          m_busy = 0;
          m_ptr  = (m_sel + 1) % 32;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("gnt", gnt, m_busy ? (32'h1 << m_sel) : 32'h0);
      chk("sel", {27'd0, sel}, 32'(m_sel));
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (m_busy && req[m_sel])});
    end
  end

  // Grant history observed on the DUT, checked against hand-computed literals.
  int  log_sel[$];
  int  log_beats[$];
  int  log_start[$];
  bit  prev_busy = 0;

  always @(negedge clk) begin
    if (busy === 1'b1 && !prev_busy) begin
      log_sel.push_back(int'(sel));
      log_beats.push_back(0);
      log_start.push_back(cyc_n);
    end
    if (busy === 1'b1 && out_valid === 1'b1 && out_ready && log_beats.size() > 0)
      log_beats[log_beats.size() - 1] += 1;
    prev_busy = (busy === 1'b1);
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [31:0] r);
    req = r;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic clear_log();
    log_sel.delete();
    log_beats.delete();
    log_start.delete();
  endtask

  task automatic chk_entry(input string name, input int i, input int esel, input int ebeats);
    chk({name, "_present"}, 32'(log_sel.size() > i), 32'd1);
    if (log_sel.size() > i) begin
      chk({name, "_sel"}, 32'(log_sel[i]), 32'(esel));
      if (ebeats >= 0) chk({name, "_beats"}, 32'(log_beats[i]), 32'(ebeats));
    end
  endtask

  task automatic chk_gap(input string name, input int i, input int egap);
    if (log_start.size() > i + 1)
      chk(name, 32'(log_start[i + 1] - log_start[i]), 32'(egap));
  endtask

  initial begin
    // 1: reset with every requester asking
    out_ready = 1'b1;
    do_reset(32'hFFFF_FFFF);
    chk("rst_gnt", gnt, 32'h0);
    chk("rst_sel", {27'd0, sel}, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    cyc();
    chk("post_rst_gnt", gnt, 32'h1);

    // 2: single requester, full bursts with one bubble between
    do_reset(32'h0);
    req = 32'h20; clear_log();
    cyc(14);
    chk_entry("s2_g0", 0, 5, 4);
    chk_entry("s2_g1", 1, 5, 4);
    chk_gap("s2_gap", 0, MB + 1);

    // 3: fairness between 3 and 7
    do_reset(32'h0);
    req = 32'h88; clear_log();
    cyc(22);
    chk_entry("s3_g0", 0, 3, 4);
    chk_entry("s3_g1", 1, 7, 4);
    chk_entry("s3_g2", 2, 3, 4);
    chk_entry("s3_g3", 3, 7, -1);
    chk_gap("s3_gap0", 0, MB + 1);
    chk_gap("s3_gap1", 1, MB + 1);

    // 4: pointer wraps from 31 to 0
    do_reset(32'h0);
    req = 32'h8000_0000; clear_log();
    cyc();
    req = 32'h4000_0001;
    cyc(12);
    chk_entry("s4_g0", 0, 31, 0);
    chk_entry("s4_g1", 1, 0, 4);
    chk_entry("s4_g2", 2, 30, -1);

    // 5: backpressure holds the grant
    do_reset(32'h0);
    out_ready = 1'b0;
    req = 32'h200; clear_log();
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("s5_gnt_hold", gnt, 32'h200);
      chk("s5_valid_hold", {31'd0, out_valid}, 32'h1);
      cyc();
    end
    out_ready = 1'b1;
    cyc(4);
    chk("s5_released", {31'd0, busy}, 32'h0);
    chk_entry("s5_g0", 0, 9, 4);

    // 6a: requester 12 drops after two beats; next search starts at 13
    do_reset(32'h0);
    req = 32'h1000; clear_log();
    cyc(3);
    req = 32'h0000_4800;
    cyc();
    chk("s6_release", {31'd0, busy}, 32'h0);
    cyc(2);
    chk_entry("s6_g0", 0, 12, 2);
    chk_entry("s6_g1", 1, 14, -1);

    // 6b: reset in the middle of a burst
    do_reset(32'h0);
    req = 32'h10_0000;
    cyc(2);
    rst = 1'b1;
    cyc();
    chk("s6b_gnt", gnt, 32'h0);
    chk("s6b_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    cyc();
    chk("s6b_regrant", gnt, 32'h10_0000);
    req = 32'h0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
